// File: rtl/toggle_pulse_gen_pkg.sv
// Shared definitions for the toggle pulse generator: debounce FSM state
// encodings and elaboration-time helpers for parameter sizing and legality.
package toggle_pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } toggle_state_t;

    // Largest of three timing parameters; sets the counter ceiling.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

    // Parameter set is usable: minimum timings met and counter wide enough.
    function automatic bit params_legal(input int unsigned debounce_cycles,
                                        input int unsigned repeat_delay,
                                        input int unsigned repeat_period,
                                        input int unsigned cnt_w);
        bit ok;
        ok = 1'b1;
        if (debounce_cycles < 32'd2) begin
            ok = 1'b0;
        end
        if (repeat_delay < 32'd1) begin
            ok = 1'b0;
        end
        if (repeat_period < 32'd1) begin
            ok = 1'b0;
        end
        if ((cnt_w < 32'd1) || (cnt_w > 32'd31)) begin
            ok = 1'b0;
        end else if (max3(debounce_cycles, repeat_delay, repeat_period) > (32'd1 << cnt_w)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/toggle_pulse_gen_sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset, for
// bringing raw asynchronous levels into the clk domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // Two back-to-back capture stages; only the second is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_q <= {WIDTH{1'b0}};
            stage2_q <= {WIDTH{1'b0}};
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/toggle_pulse_gen.sv
// Button conditioning for a toggle flip-flop: synchronizes a raw button level,
// debounces it with a stability counter and emits a one-cycle toggle pulse
// per accepted press, optionally followed by hold-to-auto-repeat pulses.
module toggle_pulse_gen
    import toggle_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = 5000,
    parameter int unsigned REPEAT_PERIOD   = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic t_out,
    output logic btn_level,
    output logic bounce_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(REPEAT_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(REPEAT_PERIOD - 32'd1);
    localparam logic [CNT_W-1:0] CNT_LIMIT    =
        CNT_W'(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) - 32'd1);
    localparam bit PARAMS_OK = params_legal(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                            REPEAT_PERIOD, CNT_W);

    if (!PARAMS_OK) begin : g_param_check
        $error("toggle_pulse_gen: illegal parameter combination");
    end

    logic          btn_s;
    toggle_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          rep_first_q, rep_first_d;  // next repeat uses REPEAT_DELAY
    logic          t_out_q, t_out_d;
    logic          btn_level_q, btn_level_d;
    logic          bounce_err_q, bounce_err_d;
    logic          repeat_due_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

    // Repeat deadline: first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    always_comb begin
        repeat_due_s = 1'b0;
        if (rep_first_q) begin
            repeat_due_s = (cnt_q == DELAY_LAST);
        end else begin
            repeat_due_s = (cnt_q == PERIOD_LAST);
        end
    end

    // Debounce FSM next-state, counter and registered-output next values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rep_first_d  = rep_first_q;
        t_out_d      = 1'b0;
        btn_level_d  = btn_level_q;
        bounce_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                btn_level_d = 1'b0;
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d      = IDLE;
                    cnt_d        = CNT_ZERO;
                    bounce_err_d = 1'b1;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = CNT_ZERO;
                    rep_first_d = 1'b1;
                    t_out_d     = 1'b1;
                    btn_level_d = 1'b1;
                end else if (cnt_q < CNT_LIMIT) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end

            PRESSED: begin
                btn_level_d = 1'b1;
                // Release is checked first so it beats a coincident repeat.
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (!REPEAT_EN) begin
                    cnt_d = CNT_ZERO;
                end else if (repeat_due_s) begin
                    // Hold off one cycle rather than emit back-to-back pulses.
                    if (!t_out_q) begin
                        t_out_d     = 1'b1;
                        cnt_d       = CNT_ZERO;
                        rep_first_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (cnt_q < CNT_LIMIT) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end

            RELEASE_WAIT: begin
                btn_level_d = 1'b1;
                if (btn_s) begin
                    // Release rejected: back to held, repeat timing restarts.
                    state_d      = PRESSED;
                    cnt_d        = CNT_ZERO;
                    rep_first_d  = 1'b1;
                    bounce_err_d = 1'b1;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = CNT_ZERO;
                    btn_level_d = 1'b0;
                end else if (cnt_q < CNT_LIMIT) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end

            default: begin
                state_d     = IDLE;
                cnt_d       = CNT_ZERO;
                rep_first_d = 1'b1;
                btn_level_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            rep_first_q  <= 1'b1;
            t_out_q      <= 1'b0;
            btn_level_q  <= 1'b0;
            bounce_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rep_first_q  <= rep_first_d;
            t_out_q      <= t_out_d;
            btn_level_q  <= btn_level_d;
            bounce_err_q <= bounce_err_d;
        end
    end

    assign t_out      = t_out_q;
    assign btn_level  = btn_level_q;
    assign bounce_err = bounce_err_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed-vector bench for toggle_pulse_gen. Cycle c is the interval after
// rising edge c; inputs driven in cycle c are sampled at edge c+1.
module tb_toggle_pulse_gen;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic t_out;
    logic btn_level;
    logic bounce_err;
    logic tff_q;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    toggle_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .CNT_W           (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .t_out      (t_out),
        .btn_level  (btn_level),
        .bounce_err (bounce_err)
    );

    // Downstream T flip-flop fed by the toggle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            tff_q <= 1'b0;
        end else if (t_out) begin
            tff_q <= ~tff_q;
        end else begin
            tff_q <= tff_q;
        end
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0b, expected %0b", tag, obs, exp);
        end
    endtask

    // Button input schedule per scenario.
    function automatic logic sched_btn(input int id, input int c);
        case (id)
            1: return c >= 10;
            2: return (c == 10) || (c == 11) || (c >= 13);
            3: return (c >= 10) && (c <= 60);
            4: return (c >= 10) && !((c == 20) || (c == 21));
            5: return c >= 10;
            6: return ((c >= 10) && (c <= 20)) || ((c >= 30) && (c <= 40)) ||
                      ((c >= 50) && (c <= 60));
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_t(input int id, input int c);
        case (id)
            1: return c == 16;
            2: return c == 19;
            3: return (c == 16) || (c == 36) || (c == 44) || (c == 52) || (c == 60);
            4: return (c == 16) || (c == 45) || (c == 53);
            5: return c == 21;
            6: return (c == 16) || (c == 36) || (c == 56);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_lvl(input int id, input int c);
        case (id)
            1: return c >= 16;
            2: return c >= 19;
            3: return (c >= 16) && (c < 67);
            4: return c >= 16;
            5: return c >= 21;
            6: return ((c >= 16) && (c < 27)) || ((c >= 36) && (c < 47)) ||
                      ((c >= 56) && (c < 67));
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_err(input int id, input int c);
        case (id)
            2: return c == 15;
            4: return c == 25;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_q(input int c);
        return ((c >= 17) && (c < 37)) || (c >= 57);
    endfunction

    task automatic run_scenario(input int id, input int ncyc);
        btn_in = 1'b0;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit($sformatf("s%0d reset t_out", id), t_out, 1'b0);
        check_bit($sformatf("s%0d reset btn_level", id), btn_level, 1'b0);
        check_bit($sformatf("s%0d reset bounce_err", id), bounce_err, 1'b0);
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            btn_in = sched_btn(id, c);
            reset  = (id == 5) && (c == 14);
            #3;
            check_bit($sformatf("s%0d c%0d t_out", id, c), t_out, exp_t(id, c));
            check_bit($sformatf("s%0d c%0d btn_level", id, c), btn_level, exp_lvl(id, c));
            check_bit($sformatf("s%0d c%0d bounce_err", id, c), bounce_err, exp_err(id, c));
            if (id == 6) begin
                check_bit($sformatf("s%0d c%0d tff_q", id, c), tff_q, exp_q(c));
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;
        run_scenario(1, 30);   // clean press
        run_scenario(2, 30);   // press bounce
        run_scenario(3, 75);   // auto-repeat then release
        run_scenario(4, 56);   // release bounce restarts repeat delay
        run_scenario(5, 35);   // reset mid-press
        run_scenario(6, 70);   // three presses into T flip-flop
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
